// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter: result packet layout,
// FU index assignments and the fixed base priority order.
package wb_arbiter_pkg;

    localparam int EPOCH_W  = 3;
    localparam int ROB_W    = 6;
    localparam int PHYS_W   = 7;
    localparam int XLEN     = 32;
    localparam int FU_IDX_W = 2;

    localparam logic [FU_IDX_W-1:0] FU_ALU = 2'd0;
    localparam logic [FU_IDX_W-1:0] FU_BRU = 2'd1;
    localparam logic [FU_IDX_W-1:0] FU_LD  = 2'd2;
    localparam logic [FU_IDX_W-1:0] FU_ST  = 2'd3;

    typedef struct packed {
        logic [ROB_W-1:0]   rob_idx;
        logic [PHYS_W-1:0]  prd_new;
        logic [XLEN-1:0]    data;
        logic [EPOCH_W-1:0] epoch;
        logic               uses_rd;
        logic               data_valid;
        logic [XLEN-1:0]    pc;
        logic               br_taken;
        logic [XLEN-1:0]    br_target;
        logic               br_mispredict;
    } fu_wb_t;

    // Element 0 is searched first: BRU, then LD, ALU, ST.
    localparam logic [3:0][FU_IDX_W-1:0] BASE_ORDER = {FU_ST, FU_ALU, FU_LD, FU_BRU};

    // A packet is stale when a recovery is in progress and it belongs to another epoch.
    function automatic logic epoch_stale(input logic               rec_valid,
                                         input logic [EPOCH_W-1:0] pkt_epoch,
                                         input logic [EPOCH_W-1:0] rec_epoch);
        return rec_valid & (pkt_epoch != rec_epoch);
    endfunction

endpackage

// File: rtl/wb_prio_pick.sv
// Combinational picker: starved requesters win (lowest index first), otherwise
// the first valid requester in the supplied base order. Returns one-hot + index.
module wb_prio_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]            valid_i,
    input  logic [N-1:0]            starved_i,
    input  logic [N-1:0][IDX_W-1:0] order_i,
    output logic [N-1:0]            grant_o,
    output logic [IDX_W-1:0]        idx_o,
    output logic                    any_o
);

    logic         found_s;
    logic [N-1:0] starved_v_s;

    // Two-tier search: starved set by index, then base order.
    always_comb begin
        grant_o     = '0;
        idx_o       = '0;
        found_s     = 1'b0;
        starved_v_s = valid_i & starved_i;
        for (int i = 0; i < N; i++) begin
            if (!found_s && starved_v_s[i]) begin
                found_s = 1'b1;
                idx_o   = IDX_W'(i);
            end else begin
                found_s = found_s;
            end
        end
        for (int p = 0; p < N; p++) begin
            if (!found_s && valid_i[order_i[p]]) begin
                found_s = 1'b1;
                idx_o   = order_i[p];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            grant_o[idx_o] = 1'b1;
        end else begin
            grant_o = '0;
        end
        any_o = found_s;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one FU result per cycle into a one-entry output
// register driving the ROB/PRF bus. Optional starvation guard: WB_STARVE_GUARD_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  fu_wb_t              req_pkt [N_REQ],
    input  logic                flush_valid,
    input  logic                recover_valid,
    input  logic [EPOCH_W-1:0]  recover_epoch,
    output logic                wb_valid,
    input  logic                wb_ready,
    output fu_wb_t              wb_pkt,
    output logic [1:0]          grant_idx
);

    if (STARVE_LIMIT >= (1 << CNT_W)) begin : g_bad_cfg
        $error("wb_arbiter: STARVE_LIMIT must be below 2**CNT_W");
    end

    logic                    out_v_q, out_v_d;
    fu_wb_t                  pkt_q, pkt_d;
    logic [FU_IDX_W-1:0]     gidx_q, gidx_d;
    logic                    slot_free_s;
    logic                    any_grant_s;
    logic [N_REQ-1:0]        pick_valid_s;
    logic [N_REQ-1:0]        grant_oh_s;
    logic [N_REQ-1:0]        starved_s;
    logic [FU_IDX_W-1:0]     pick_idx_s;

    assign slot_free_s  = ~out_v_q | (out_v_q & wb_ready);
    assign pick_valid_s = (slot_free_s & ~flush_valid) ? req_valid : '0;
    assign req_ready    = grant_oh_s;
    assign wb_valid     = out_v_q;
    assign wb_pkt       = pkt_q;
    assign grant_idx    = gidx_q;

    wb_prio_pick #(
        .N     (N_REQ),
        .IDX_W (FU_IDX_W)
    ) u_pick (
        .valid_i   (pick_valid_s),
        .starved_i (starved_s),
        .order_i   (BASE_ORDER),
        .grant_o   (grant_oh_s),
        .idx_o     (pick_idx_s),
        .any_o     (any_grant_s)
    );

`ifdef WB_STARVE_GUARD_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];

    // Per-requester wait counters; only cycles with a free slot count as denied.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i]     = cnt_q[i];
            starved_s[i] = (cnt_q[i] >= CNT_W'(STARVE_LIMIT));
            if (flush_valid || !req_valid[i] || grant_oh_s[i]) begin
                cnt_d[i] = '0;
            end else if (slot_free_s && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    assign starved_s = '0;
`endif

    // Output slot next state: flush wins, then a new grant, then pop, then recovery kill.
    always_comb begin
        out_v_d = out_v_q;
        pkt_d   = pkt_q;
        gidx_d  = gidx_q;
        if (flush_valid) begin
            out_v_d = 1'b0;
        end else if (any_grant_s) begin
            pkt_d   = req_pkt[pick_idx_s];
            gidx_d  = pick_idx_s;
            // Stale grants still drain the FU but never reach the bus.
            out_v_d = ~epoch_stale(recover_valid, req_pkt[pick_idx_s].epoch, recover_epoch);
        end else if (out_v_q && wb_ready) begin
            out_v_d = 1'b0;
        end else if (out_v_q && epoch_stale(recover_valid, pkt_q.epoch, recover_epoch)) begin
            out_v_d = 1'b0;
        end else begin
            out_v_d = out_v_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q <= 1'b0;
            pkt_q   <= '0;
            gidx_q  <= '0;
        end else begin
            out_v_q <= out_v_d;
            pkt_q   <= pkt_d;
            gidx_q  <= gidx_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic,
// all compared against a behavioural model of the arbitration rules.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int STARVE_LIMIT = 8;
    localparam int CNT_MAX      = 15;
`ifdef WB_STARVE_GUARD_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         req_valid;
    logic [3:0]         req_ready;
    fu_wb_t             req_pkt [4];
    logic               flush_valid;
    logic               recover_valid;
    logic [EPOCH_W-1:0] recover_epoch;
    logic               wb_valid;
    logic               wb_ready;
    fu_wb_t             wb_pkt;
    logic [1:0]         grant_idx;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit     m_v;
    fu_wb_t m_pkt;
    int     m_idx;
    int     m_cnt [4];

    always #5 clk = ~clk;

    wb_arbiter #(.N_REQ(4), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_pkt       (req_pkt),
        .flush_valid   (flush_valid),
        .recover_valid (recover_valid),
        .recover_epoch (recover_epoch),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_pkt        (wb_pkt),
        .grant_idx     (grant_idx)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic fu_wb_t rand_pkt();
        fu_wb_t p;
        p.rob_idx       = ROB_W'($urandom());
        p.prd_new       = PHYS_W'($urandom());
        p.data          = $urandom();
        p.epoch         = EPOCH_W'($urandom());
        p.uses_rd       = 1'($urandom());
        p.data_valid    = 1'($urandom());
        p.pc            = $urandom();
        p.br_taken      = 1'($urandom());
        p.br_target     = $urandom();
        p.br_mispredict = 1'($urandom());
        return p;
    endfunction

    // Winner by the rules: starved (lowest index), else BRU > LD > ALU > ST; -1 if none.
    function automatic int model_pick(input logic [3:0] v);
        int prio [4] = '{1, 2, 0, 3};
        if (STARVE_EN) begin
            for (int i = 0; i < 4; i++)
                if (v[i] && m_cnt[i] >= STARVE_LIMIT) return i;
        end
        foreach (prio[k])
            if (v[prio[k]]) return prio[k];
        return -1;
    endfunction

    // One clock: check req_ready before the edge, advance the model, check outputs after.
    task automatic cycle(output int g);
        bit slot_free;
        logic [3:0] exp_ready;
        #2;
        slot_free = !m_v || wb_ready;
        g = (slot_free && !flush_valid) ? model_pick(req_valid) : -1;
        exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("req_ready", 128'(req_ready), 128'(exp_ready));
        for (int i = 0; i < 4; i++) begin
            if (flush_valid || !req_valid[i] || g == i) m_cnt[i] = 0;
            else if (slot_free) m_cnt[i] = (m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX;
        end
        if (flush_valid) m_v = 1'b0;
        else if (g >= 0) begin
            m_pkt = req_pkt[g];
            m_idx = g;
            m_v   = !(recover_valid && req_pkt[g].epoch != recover_epoch);
        end else if (m_v && wb_ready) m_v = 1'b0;
        else if (m_v && recover_valid && m_pkt.epoch != recover_epoch) m_v = 1'b0;
        @(posedge clk);
        #1;
        chk("wb_valid", 128'(wb_valid), 128'(m_v));
        chk("wb_pkt", 128'(wb_pkt), 128'(m_pkt));
        chk("grant_idx", 128'(grant_idx), 128'(m_idx[1:0]));
    endtask

    initial begin
        int     g;
        int     st_at;
        fu_wb_t held;

        rst_n = 1'b0; req_valid = '0; flush_valid = 1'b0; recover_valid = 1'b0;
        recover_epoch = '0; wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) req_pkt[i] = '0;
        m_v = 1'b0; m_pkt = '0; m_idx = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", 128'(wb_valid), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_wb_pkt", 128'(wb_pkt), 128'(0));
        chk("rst_grant_idx", 128'(grant_idx), 128'(0));
        rst_n = 1'b1;
        cycle(g);

        // ALU alone, one-cycle latency
        wb_ready = 1'b1;
        req_pkt[0] = rand_pkt(); req_pkt[0].data = 32'h0000_1234;
        req_valid = 4'b0001;
        cycle(g);
        chk("alu_grant", 128'(g), 128'(0));
        chk("alu_data", 128'(wb_pkt.data), 128'(32'h0000_1234));
        chk("alu_valid", 128'(wb_valid), 128'(1));
        req_valid = 4'b0000;

        // ALU+BRU+LD: BRU, LD, ALU back to back
        for (int i = 0; i < 3; i++) req_pkt[i] = rand_pkt();
        req_valid = 4'b0111;
        cycle(g); chk("order0", 128'(grant_idx), 128'(1)); req_valid[g] = 1'b0;
        cycle(g); chk("order1", 128'(grant_idx), 128'(2)); req_valid[g] = 1'b0;
        cycle(g); chk("order2", 128'(grant_idx), 128'(0)); req_valid[g] = 1'b0;
        chk("order_nobubble", 128'(wb_valid), 128'(1));

        // Backpressure: packet stable, LD waits, then goes next cycle
        held = wb_pkt;
        wb_ready = 1'b0;
        req_pkt[2] = rand_pkt(); req_valid = 4'b0100;
        repeat (3) cycle(g);
        chk("bp_stable", 128'(wb_pkt), 128'(held));
        wb_ready = 1'b1;
        cycle(g);
        chk("bp_ld_idx", 128'(grant_idx), 128'(2));
        chk("bp_ld_pkt", 128'(wb_pkt), 128'(req_pkt[2]));
        req_valid = 4'b0000;

        // Recovery kills a stale held packet, keeps a surviving one
        req_pkt[0] = rand_pkt(); req_pkt[0].epoch = 3'd2; req_valid = 4'b0001;
        cycle(g); req_valid = 4'b0000;
        wb_ready = 1'b0; recover_valid = 1'b1; recover_epoch = 3'd3;
        cycle(g);
        chk("rec_kill", 128'(wb_valid), 128'(0));
        recover_valid = 1'b0;
        req_pkt[0] = rand_pkt(); req_pkt[0].epoch = 3'd3; req_valid = 4'b0001;
        cycle(g); req_valid = 4'b0000;
        recover_valid = 1'b1;
        cycle(g);
        chk("rec_keep", 128'(wb_valid), 128'(1));
        recover_valid = 1'b0;

        // Flush with ST waiting
        req_pkt[3] = rand_pkt(); req_valid = 4'b1000; flush_valid = 1'b1;
        cycle(g);
        chk("flush_valid", 128'(wb_valid), 128'(0));
        flush_valid = 1'b0; wb_ready = 1'b1;
        cycle(g);
        chk("flush_st_after", 128'(grant_idx), 128'(3));
        req_valid = 4'b0000;
        cycle(g);

        // Starvation: BRU always valid, ST waiting
        st_at = -1;
        req_pkt[1] = rand_pkt(); req_pkt[3] = rand_pkt(); req_valid = 4'b1010;
        for (int c = 0; c < 20; c++) begin
            cycle(g);
            if (g == 3 && st_at < 0) begin st_at = c; req_valid[3] = 1'b0; end
            if (g == 1) req_pkt[1] = rand_pkt();
        end
        chk("starve_cycle", 128'(st_at), STARVE_EN ? 128'(8) : 128'(-1));
        req_valid = 4'b0000;
        cycle(g);

        // Random traffic; FUs hold requests until granted
        for (int c = 0; c < 400; c++) begin
            wb_ready      = ($urandom_range(0, 9) < 7);
            flush_valid   = ($urandom_range(0, 31) == 0);
            recover_valid = ($urandom_range(0, 9) == 0);
            recover_epoch = EPOCH_W'($urandom());
            for (int i = 0; i < 4; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_pkt[i]   = rand_pkt();
                    req_valid[i] = 1'b1;
                end
            cycle(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
